// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst read engine for fixed-latency synchronous ROMs
// Fetches burst_len consecutive words starting at base_addr (address wraps
// modulo 2**ADDR_W) and presents each one on a valid/ready stream.
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start, abort    burst request (sampled in IDLE) / synchronous cancel
//   base_addr       first word address, sampled with start
//   burst_len       word count, sampled with start, clamped to MAX_BURST
//   busy, done      activity flag / one-cycle completion pulse
//   addr_mem        registered ROM address
//   rd_mem          ROM read data, valid RD_LATENCY edges after addr_mem changes
//   data_out        captured word, data_valid / data_ready stream handshake
module rom_burst_reader #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 3,
   parameter int MAX_BURST  = 32,
   localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              busy,
   output logic [ADDR_W-1:0] addr_mem,
   input  logic [DATA_W-1:0] rd_mem,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              done
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

   // Counter is loaded with RD_LATENCY-1 on the edge that updates addr_mem and
   // the capture happens on the WAIT edge where it reads zero, i.e. exactly
   // RD_LATENCY edges after the address change.
   localparam logic [3:0] WAIT_LOAD = 4'(RD_LATENCY - 1);

   state_t             state, state_n;
   logic [ADDR_W-1:0]  base_q;
   logic [LEN_W-1:0]   remaining;
   logic [3:0]         wait_cnt;
   logic [LEN_W-1:0]   len_clamped;

   logic load, issue, capture, advance, cnt_dec, handshake, cancel;

   assign len_clamped = (burst_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : burst_len;
   assign cancel      = abort && (state != S_IDLE);
   // data_valid is only ever high in HOLD, so this is the stream handshake.
   // It still counts when abort arrives on the same edge.
   assign handshake   = (state == S_HOLD) && data_ready;

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      issue   = 1'b0;
      capture = 1'b0;
      advance = 1'b0;
      cnt_dec = 1'b0;
      if (cancel) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  load    = 1'b1;
                  state_n = (len_clamped == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               issue   = 1'b1;
               state_n = S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  capture = 1'b1;
                  state_n = S_HOLD;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            S_HOLD: begin
               if (data_ready) begin
                  if (remaining == LEN_W'(1)) begin
                     state_n = S_DONE;
                  end else begin
                     advance = 1'b1;
                     state_n = S_WAIT;
                  end
               end
            end
            S_DONE: begin
               state_n = S_IDLE;
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q     <= '0;
         remaining  <= '0;
         wait_cnt   <= '0;
         addr_mem   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         if (load) begin
            base_q    <= base_addr;
            remaining <= len_clamped;
         end
         if (issue) begin
            addr_mem <= base_q;
            wait_cnt <= WAIT_LOAD;
         end
         if (advance) begin
            addr_mem <= addr_mem + ADDR_W'(1);
            wait_cnt <= WAIT_LOAD;
         end
         if (cnt_dec) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (capture) begin
            data_out   <= rd_mem;
            data_valid <= 1'b1;
         end
         if (handshake) begin
            data_valid <= 1'b0;
            remaining  <= remaining - LEN_W'(1);
         end
         if (cancel) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb/tb_rom_burst_reader.sv - self-checking bench for rom_burst_reader
module tb_rom_burst_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [4:0] base_addr;
   logic [5:0] burst_len;
   logic       data_ready;

   logic       busy0, valid0, done0, busy1, valid1, done1;
   logic [4:0] addr0, addr1;
   logic [7:0] dout0, dout1, rd0, rd1;

   logic [7:0] rom [32];
   logic [7:0] pipe0, pipe1;

   bit         sel;
   logic       o_busy, o_valid, o_done;
   logic [4:0] o_addr;
   logic [7:0] o_data;

   int vec_cnt = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   rom_burst_reader dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .burst_len(burst_len), .busy(busy0),
      .addr_mem(addr0), .rd_mem(rd0), .data_out(dout0),
      .data_valid(valid0), .data_ready(data_ready), .done(done0)
   );

   rom_burst_reader #(.RD_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .base_addr(base_addr), .burst_len(burst_len), .busy(busy1),
      .addr_mem(addr1), .rd_mem(rd1), .data_out(dout1),
      .data_valid(valid1), .data_ready(data_ready), .done(done1)
   );

   // ROM for latency 3: two registers after the address, so the word for an
   // address change at edge n is present just before edge n+3.
   always @(posedge clk) begin
      pipe0 <= rom[addr0];
      pipe1 <= pipe0;
   end
   assign rd0 = pipe1;
   assign rd1 = rom[addr1];

   assign o_busy  = sel ? busy1  : busy0;
   assign o_valid = sel ? valid1 : valid0;
   assign o_done  = sel ? done1  : done0;
   assign o_addr  = sel ? addr1  : addr0;
   assign o_data  = sel ? dout1  : dout0;

   typedef struct {
      int base;
      int len;
      int exp_beats;
      int stall_beat;
      int stall_cyc;
      bit noise;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input int act, input int exp);
      vec_cnt++;
      if (act != exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_burst(input int b, input int l, input int exp_beats,
                            input int stall_beat, input int stall_cyc,
                            input bit noise, input int lat);
      int k, beat, h_last, stall_left, exp_a;
      bit seen_done, pending;
      @(negedge clk);
      start = 1'b1; base_addr = 5'(b); burst_len = 6'(l); data_ready = 1'b1;
      k = 0; beat = 0; h_last = 0; stall_left = stall_cyc;
      seen_done = 1'b0; pending = 1'b0;
      while (!seen_done && k < 600) begin
         @(negedge clk);
         k++;
         start = noise && (k <= 3);
         if (start) begin
            base_addr = 5'(b + 9);
            burst_len = 6'd5;
         end
         chk("busy_during_burst", int'(o_busy), 1);
         data_ready = 1'b1;
         if (o_valid) begin
            if (!pending)
               chk("valid_cycle", k, (beat == 0) ? lat + 2 : h_last + lat + 1);
            exp_a = (b + beat) % 32;
            chk("addr_mem", int'(o_addr), exp_a);
            chk("data_out", int'(o_data), int'(rom[exp_a]));
            if (beat == stall_beat && stall_left > 0) begin
               data_ready = 1'b0;
               stall_left--;
            end
            if (data_ready) begin
               h_last = k;
               beat++;
            end
         end
         pending = o_valid && !data_ready;
         if (o_done) begin
            seen_done = 1'b1;
            chk("done_cycle", k, h_last + 1);
            chk("beat_count", beat, exp_beats);
         end
      end
      if (!seen_done) chk("done_timeout", 0, 1);
      start = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", int'(o_done), 0);
      chk("busy_after_done", int'(o_busy), 0);
      chk("valid_after_done", int'(o_valid), 0);
   endtask

   task automatic check_quiet(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk({name, "_no_done"}, int'(o_done), 0);
         chk({name, "_no_valid"}, int'(o_valid), 0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0;
      burst_len = '0; data_ready = 1'b1; sel = 1'b0;
      for (int i = 0; i < 32; i++) rom[i] = 8'(i * 29 + 3);
      rom[7] = 8'hA5;

      //        base len beats stall_beat stall_cyc noise
      vecs[0] = '{7,  1,  1,    -1,        0,        0};
      vecs[1] = '{30, 4,  4,    -1,        0,        0};
      vecs[2] = '{3,  5,  5,     2,       10,        0};
      vecs[3] = '{12, 0,  0,    -1,        0,        0};
      vecs[4] = '{20, 40, 32,   -1,        0,        0};
      vecs[5] = '{31, 2,  2,     0,        3,        0};
      vecs[6] = '{2,  2,  2,    -1,        0,        1};

      repeat (2) @(negedge clk);
      chk("reset_busy", int'(busy0), 0);
      chk("reset_valid", int'(valid0), 0);
      chk("reset_done", int'(done0), 0);
      chk("reset_addr", int'(addr0), 0);
      chk("reset_data", int'(dout0), 0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++)
         run_burst(vecs[i].base, vecs[i].len, vecs[i].exp_beats,
                   vecs[i].stall_beat, vecs[i].stall_cyc, vecs[i].noise, 3);

      // abort while waiting on the ROM, with a competing start
      @(negedge clk);
      start = 1'b1; base_addr = 5'd5; burst_len = 6'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1; start = 1'b1; base_addr = 5'd17;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("abort_wait_busy", int'(o_busy), 0);
      chk("abort_wait_valid", int'(o_valid), 0);
      check_quiet("abort_wait", 8);
      run_burst(9, 2, 2, -1, 0, 0, 3);

      // abort on the same edge as a handshake
      @(negedge clk);
      start = 1'b1; base_addr = 5'd10; burst_len = 6'd3; data_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && !o_valid; i++) @(negedge clk);
      chk("abort_hs_valid_seen", int'(o_valid), 1);
      chk("abort_hs_data", int'(o_data), int'(rom[10]));
      data_ready = 1'b1; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_hs_busy", int'(o_busy), 0);
      chk("abort_hs_valid", int'(o_valid), 0);
      check_quiet("abort_hs", 8);
      run_burst(0, 3, 3, -1, 0, 0, 3);

      // asynchronous reset while a word is held
      @(negedge clk);
      start = 1'b1; base_addr = 5'd4; burst_len = 6'd3; data_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && !o_valid; i++) @(negedge clk);
      chk("hold_valid_seen", int'(o_valid), 1);
      chk("hold_addr", int'(o_addr), 4);
      #2 reset = 1'b1;
      #1;
      chk("async_busy", int'(busy0), 0);
      chk("async_valid", int'(valid0), 0);
      chk("async_done", int'(done0), 0);
      chk("async_addr", int'(addr0), 0);
      chk("async_data", int'(dout0), 0);
      @(negedge clk);
      reset = 1'b0; data_ready = 1'b1;
      check_quiet("after_reset", 6);
      run_burst(28, 6, 6, 4, 2, 0, 3);

      // latency-1 build, wrap burst
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sel = 1'b1;
      run_burst(30, 4, 4, -1, 0, 0, 1);
      run_burst(31, 3, 3, 1, 4, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
